vending_machine_param: RTL and testbench
========================================

// Module: vending_machine_param
// PURPOSE
//   Parametrised credit-accumulating vending controller. Sums coin credit and vends one item
//   once credit >= PRICE. Returns leftover or cancelled credit as change units over a
//   valid/ready handshake. Sits between the coin acceptor front-end and the dispenser/change hoppers.
// PARAMETERS
//   CREDIT_W   8   width of the credit accumulator
//   PRICE      15  item price, in credit units
//   COIN1_VAL  5   credit value of coin code 2'b01
//   COIN2_VAL  10  credit value of coin code 2'b10
//   CHG_UNIT   5   value of one returned change coin
//   STOCK_INIT 16  initial item count; used only with VM_STOCK_EN
// PORTS
//   clk           in   1         system clock
//   reset         in   1         synchronous, active-high reset
//   coin          in   2         00 none, 01 coin1, 10 coin2, 11 invalid; sampled every cycle
//   cancel        in   1         request refund of current credit
//   out           out  1         vend strobe, 1-cycle pulse per item
//   coin_reject   out  1         1-cycle pulse: coin this cycle not credited, send to return chute
//   change_valid  out  1         one CHG_UNIT coin offered
//   change_ready  in   1         hopper accepts the offered coin
//   credit        out  CREDIT_W  current credit, registered
//   busy          out  1         high in VEND or REFUND
//   sold_out      out  1         stock exhausted; constant 0 without VM_STOCK_EN
// BEHAVIOUR
//   Reset: state IDLE; credit=0; out, coin_reject, change_valid, busy and sold_out all 0.
//     Reset mid-REFUND discards remaining credit.
//   FSM states:
//     IDLE    credit==0
//     COLLECT 0<credit<PRICE
//     VEND    out=1 for exactly this one cycle
//     REFUND  change_valid=1
//   Coin accept (IDLE/COLLECT only): valid coin at edge k -> credit+=value at k.
//     new credit >= PRICE -> VEND in cycle k+1. Otherwise -> COLLECT.
//   VEND exit, next edge: credit-=PRICE; go to REFUND if credit>0, else IDLE.
//   Rejected coins (coin_reject pulses next cycle, credit unchanged):
//     - code 11;
//     - any non-zero coin in VEND or REFUND;
//     - a coin whose add would overflow CREDIT_W.
//   cancel in COLLECT -> REFUND. cancel in IDLE, VEND or REFUND: ignored.
//   cancel and coin in the same cycle: cancel wins, the coin is rejected.
//   REFUND handshake:
//     - change_valid stays high while credit>0;
//     - each cycle with valid&&ready: credit-=CHG_UNIT;
//     - credit reaches 0 -> IDLE the next cycle;
//     - ready low: valid and credit hold, no timeout.
//   Arithmetic: unsigned, no wrap. PRICE, COIN1_VAL and COIN2_VAL must be multiples of CHG_UNIT
//     and PRICE < 2**CREDIT_W; violation -> elaboration-time $error.
// CONFIGURATION
//   VM_STOCK_EN defined:
//     - stock counter loads STOCK_INIT on reset and decrements once per VEND;
//     - stock==0 -> sold_out=1 and every coin is rejected;
//     - credit already held can still be cancelled and refunded.
//   VM_STOCK_EN undefined: no counter, unlimited stock, sold_out tied 0.
// STRUCTURE
//   Package vm_pkg: state encoding (IDLE/COLLECT/VEND/REFUND), coin code constants COIN_NONE,
//   COIN_1, COIN_2, COIN_BAD.
//   Sub-module vm_change_dispenser: REFUND handshake and credit decrement. Top holds the FSM,
//   accumulator and stock counter.
// TESTING (PRICE=15, coins 5/10, CHG_UNIT=5, change_ready=1 unless stated)
//   1. coins 01,01,01 -> credit 5,10,15; out=1 one cycle; credit 0; no change_valid.
//   2. coins 10,10 -> out pulse; credit 5; change_valid held while ready=0 for 3 cycles;
//      ready=1 -> one handshake; credit 0; IDLE.
//   3. coin 01 then cancel -> REFUND, one change coin, IDLE. cancel+coin 10 together
//      -> coin_reject; credit unchanged until refund.
//   4. coin 11 -> coin_reject, credit 0. Coin 01 during REFUND -> coin_reject, change count unchanged.
//   5. reset asserted in REFUND with credit 10 -> next cycle credit 0, change_valid 0, IDLE.
//   6. VM_STOCK_EN, STOCK_INIT=2 -> two vends, then sold_out=1; next coin 10 -> coin_reject.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types and constants for the vending controller: FSM state encoding and coin codes.
package vm_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StVend    = 2'd2,
        StRefund  = 2'd3
    } vm_state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

endpackage

// File: rtl/vm_change_dispenser.sv
// Change-return handshake: offers one CHG_UNIT coin while refunding credit remains and
// computes the decremented credit for each accepted coin.
module vm_change_dispenser #(
    parameter int unsigned CREDIT_W = 8,
    parameter int unsigned CHG_UNIT = 5
) (
    input  logic                refund_active,
    input  logic [CREDIT_W-1:0] credit,
    input  logic                change_ready,
    output logic                change_valid,
    output logic                change_fire,
    output logic [CREDIT_W-1:0] credit_dec
);

    localparam logic [CREDIT_W-1:0] CHG_C = CREDIT_W'(CHG_UNIT);

    assign change_valid = refund_active && (credit != '0);
    assign change_fire  = change_valid && change_ready;
    // Saturate so a misconfigured remainder can never wrap into a huge refund.
    assign credit_dec   = (credit >= CHG_C) ? (credit - CHG_C) : '0;

endmodule

// File: rtl/vending_machine_param.sv
// Credit-accumulating vending controller: FSM, credit accumulator and optional stock counter.
// Define VM_STOCK_EN to enable the stock counter and sold_out; otherwise stock is unlimited.
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned PRICE      = 15,
    parameter int unsigned COIN1_VAL  = 5,
    parameter int unsigned COIN2_VAL  = 10,
    parameter int unsigned CHG_UNIT   = 5,
    parameter int unsigned STOCK_INIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                out,
    output logic                coin_reject,
    output logic                change_valid,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                sold_out
);

    if (CHG_UNIT == 0 || (PRICE % CHG_UNIT) != 0 || (COIN1_VAL % CHG_UNIT) != 0 ||
        (COIN2_VAL % CHG_UNIT) != 0 || (PRICE >> CREDIT_W) != 0) begin : g_bad_cfg
        $error("vending_machine_param: illegal price/coin/change configuration");
    end

    localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    vm_state_e           state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic                out_q;
    logic                coin_reject_q;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   credit_sum;
    logic                accepting;
    logic                coin_ok;
    logic                coin_bad;
    logic                refund_valid;
    logic                refund_fire;
    logic [CREDIT_W-1:0] refund_dec;
    logic                stock_empty;

    vm_change_dispenser #(
        .CREDIT_W (CREDIT_W),
        .CHG_UNIT (CHG_UNIT)
    ) u_change (
        .refund_active (state_q == StRefund),
        .credit        (credit_q),
        .change_ready  (change_ready),
        .change_valid  (refund_valid),
        .change_fire   (refund_fire),
        .credit_dec    (refund_dec)
    );

`ifdef VM_STOCK_EN
    localparam int unsigned STOCK_W = $clog2(STOCK_INIT + 2);
    logic [STOCK_W-1:0] stock_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stock_q <= STOCK_W'(STOCK_INIT);
        end else if (state_q == StVend && stock_q != '0) begin
            stock_q <= stock_q - 1'b1;
        end
    end

    assign stock_empty = (stock_q == '0);
`else
    assign stock_empty = 1'b0;
`endif

    always_comb begin
        coin_val = '0;
        case (coin)
            COIN_1:  coin_val = (CREDIT_W+1)'(COIN1_VAL);
            COIN_2:  coin_val = (CREDIT_W+1)'(COIN2_VAL);
            default: coin_val = '0;
        endcase
        credit_sum = {1'b0, credit_q} + coin_val;
        accepting  = (state_q == StIdle) || (state_q == StCollect);
        // Cancel takes priority over any coin presented in the same cycle.
        coin_ok    = (coin == COIN_1 || coin == COIN_2) && accepting && !cancel &&
                     !credit_sum[CREDIT_W] && !stock_empty;
        coin_bad   = (coin != COIN_NONE) && !coin_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            credit_q      <= '0;
            out_q         <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            out_q         <= 1'b0;
            coin_reject_q <= coin_bad;
            case (state_q)
                StIdle, StCollect: begin
                    if (cancel && state_q == StCollect) begin
                        state_q <= StRefund;
                    end else if (coin_ok) begin
                        credit_q <= credit_sum[CREDIT_W-1:0];
                        if (credit_sum >= PRICE_W) begin
                            state_q <= StVend;
                            out_q   <= 1'b1;
                        end else begin
                            state_q <= StCollect;
                        end
                    end
                end
                StVend: begin
                    credit_q <= credit_q - PRICE_C;
                    state_q  <= (credit_q != PRICE_C) ? StRefund : StIdle;
                end
                StRefund: begin
                    if (refund_fire) begin
                        credit_q <= refund_dec;
                        if (refund_dec == '0) state_q <= StIdle;
                    end else if (credit_q == '0) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out          = out_q;
    assign coin_reject  = coin_reject_q;
    assign change_valid = refund_valid;
    assign credit       = credit_q;
    assign busy         = (state_q == StVend) || (state_q == StRefund);
    assign sold_out     = stock_empty;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed self-checking bench for vending_machine_param (PRICE 15, coins 5/10, change 5).
module tb_vending_machine_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] coin = 2'b00;
    logic       cancel = 1'b0;
    logic       change_ready = 1'b1;
    logic       out;
    logic       coin_reject;
    logic       change_valid;
    logic [7:0] credit;
    logic       busy;
    logic       sold_out;

    int checks = 0;
    int failures = 0;
    int hs_count = 0;
    int hs_mark;

    vending_machine_param #(
        .CREDIT_W   (8),
        .PRICE      (15),
        .COIN1_VAL  (5),
        .COIN2_VAL  (10),
        .CHG_UNIT   (5),
        .STOCK_INIT (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .coin         (coin),
        .cancel       (cancel),
        .out          (out),
        .coin_reject  (coin_reject),
        .change_valid (change_valid),
        .change_ready (change_ready),
        .credit       (credit),
        .busy         (busy),
        .sold_out     (sold_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && change_valid && change_ready) hs_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic can);
        coin   = c;
        cancel = can;
        tick();
        coin   = 2'b00;
        cancel = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        coin = 2'b00;
        cancel = 1'b0;
        change_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_credit", credit, 0);
        check("rst_out", out, 0);
        check("rst_reject", coin_reject, 0);
        check("rst_cv", change_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sold", sold_out, 0);

        // 1: exact price
        hs_mark = hs_count;
        drive(2'b01, 1'b0); check("t1_c5", credit, 5);
        drive(2'b01, 1'b0); check("t1_c10", credit, 10);
        check("t1_noout", out, 0);
        drive(2'b01, 1'b0); check("t1_c15", credit, 15);
        check("t1_out", out, 1);
        check("t1_busy", busy, 1);
        tick();
        check("t1_c0", credit, 0);
        check("t1_outoff", out, 0);
        check("t1_cv", change_valid, 0);
        check("t1_idle", busy, 0);
        check("t1_hs", hs_count - hs_mark, 0);

        // 2: overpay with back-pressured change
        do_reset();
        hs_mark = hs_count;
        drive(2'b10, 1'b0); check("t2_c10", credit, 10);
        drive(2'b10, 1'b0); check("t2_c20", credit, 20);
        check("t2_out", out, 1);
        change_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_cv", change_valid, 1);
            check("t2_hold_c", credit, 5);
            check("t2_hold_out", out, 0);
        end
        change_ready = 1'b1;
        tick();
        check("t2_c0", credit, 0);
        check("t2_cv0", change_valid, 0);
        check("t2_idle", busy, 0);
        check("t2_hs", hs_count - hs_mark, 1);

        // 3: cancel, then cancel with a simultaneous coin
        do_reset();
        hs_mark = hs_count;
        drive(2'b01, 1'b0); check("t3_c5", credit, 5);
        drive(2'b00, 1'b1);
        check("t3_refund", change_valid, 1);
        check("t3_rc", credit, 5);
        tick();
        check("t3_c0", credit, 0);
        check("t3_idle", busy, 0);
        check("t3_hs", hs_count - hs_mark, 1);
        drive(2'b01, 1'b0); check("t3b_c5", credit, 5);
        drive(2'b10, 1'b1);
        check("t3b_reject", coin_reject, 1);
        check("t3b_c", credit, 5);
        check("t3b_busy", busy, 1);
        tick();
        check("t3b_rej_off", coin_reject, 0);
        check("t3b_c0", credit, 0);
        check("t3b_idle", busy, 0);

        // 4: invalid code, coin during refund
        do_reset();
        drive(2'b11, 1'b0);
        check("t4_bad_rej", coin_reject, 1);
        check("t4_bad_c", credit, 0);
        drive(2'b01, 1'b0); check("t4_c5", credit, 5);
        check("t4_rej_off", coin_reject, 0);
        change_ready = 1'b0;
        drive(2'b00, 1'b1);
        check("t4_refund", change_valid, 1);
        hs_mark = hs_count;
        drive(2'b01, 1'b0);
        check("t4_ref_rej", coin_reject, 1);
        check("t4_ref_c", credit, 5);
        check("t4_ref_hs", hs_count - hs_mark, 0);
        change_ready = 1'b1;
        tick();
        check("t4_c0", credit, 0);
        check("t4_hs", hs_count - hs_mark, 1);

        // 5: reset mid-refund
        do_reset();
        change_ready = 1'b0;
        drive(2'b10, 1'b0); check("t5_c10", credit, 10);
        drive(2'b00, 1'b1);
        check("t5_refund_c", credit, 10);
        check("t5_refund_cv", change_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_c0", credit, 0);
        check("t5_cv0", change_valid, 0);
        check("t5_idle", busy, 0);
        change_ready = 1'b1;

        // 6: stock exhaustion (or unlimited stock in the default build)
        do_reset();
        for (int v = 0; v < 2; v++) begin
            drive(2'b10, 1'b0);
            drive(2'b01, 1'b0);
            check("t6_out", out, 1);
            tick();
            check("t6_c0", credit, 0);
        end
`ifdef VM_STOCK_EN
        check("t6_sold", sold_out, 1);
        drive(2'b10, 1'b0);
        check("t6_rej", coin_reject, 1);
        check("t6_rej_c", credit, 0);
`else
        check("t6_sold", sold_out, 0);
        drive(2'b10, 1'b0);
        check("t6_acc", coin_reject, 0);
        check("t6_acc_c", credit, 10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
